// File: rtl/mps2_ahb_pkg.sv
// -----------------------------------------------------------------------------
// mps2_ahb_pkg
// Shared definitions for the MPS2 AHB response side:
//   - HTRANS encodings
//   - default-slave FSM state encoding
//   - bit positions inside the data-phase select vector dsel = {def, mps2, fpga, beetle}
//   - multi_hot(): true when more than one select bit is set
// -----------------------------------------------------------------------------
package mps2_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  localparam int DSEL_BEETLE = 0;
  localparam int DSEL_FPGA   = 1;
  localparam int DSEL_MPS2   = 2;
  localparam int DSEL_DEF    = 3;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/mps2_ahb_default_slave.sv
// -----------------------------------------------------------------------------
// mps2_ahb_default_slave
// Default-slave response generator: zero-wait OKAY for IDLE/BUSY, two-cycle
// ERROR (ERR1: not ready + ERROR, ERR2: ready + ERROR) for NONSEQ/SEQ.
// Ports:
//   hclk, hresetn   clock, asynchronous active-low reset
//   hready          bus-level HREADY (address phase accepted when 1)
//   trans_active    address phase is NONSEQ or SEQ
//   sel             default slave is the target of the current address phase
//   hreadyout       ready response (meaningful while the default slave owns the data phase)
//   hresp           response, 1 = ERROR
// -----------------------------------------------------------------------------
module mps2_ahb_default_slave
  import mps2_ahb_pkg::*;
(
  input  logic hclk,
  input  logic hresetn,
  input  logic hready,
  input  logic trans_active,
  input  logic sel,
  output logic hreadyout,
  output logic hresp
);

  ds_state_e state_reg;
  ds_state_e state_next;
  logic      start_err;

  assign start_err = sel & hready & trans_active;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg <= DS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    unique case (state_reg)
      DS_IDLE: begin
        if (start_err) state_next = DS_ERR1;
      end
      DS_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = 1'b1;
        state_next = DS_ERR2;
      end
      DS_ERR2: begin
        // Last cycle of the ERROR is also an address-phase acceptance point,
        // so a new erroring transfer chains straight into ERR1.
        hresp      = 1'b1;
        state_next = start_err ? DS_ERR1 : DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/mps2_ahb_resp_mux.sv
// -----------------------------------------------------------------------------
// mps2_ahb_resp_mux
// AHB response multiplexer for the MPS2 subsystem. Registers the decoder's
// address-phase selects into a data-phase select (dsel) and returns the
// selected slave's HREADYOUT/HRESP/HRDATA; hosts the default slave.
// Ports:
//   HCLK, HRESETn                clock, asynchronous active-low reset
//   HREADY, HTRANS               bus-level ready and address-phase transfer type
//   *_HSEL_i                     address-phase selects (beetle, fpga, mps2, default)
//   *_HREADYOUT_i/_HRESP_i/_HRDATA_i  slave responses
//   HREADYOUT_o, HRESP_o, HRDATA_o    muxed response to the master
// Build option:
//   MPS2_AHB_RESP_MUX_ONEHOT_CHK_EN  overlapping selects are routed to the
//                                    default slave and answered with ERROR.
// -----------------------------------------------------------------------------
module mps2_ahb_resp_mux
  import mps2_ahb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic          BEETLE_HSEL_i,
  input  logic          FPGA_HSEL_i,
  input  logic          MPS2_HSEL_i,
  input  logic          DEFSLAVE_HSEL_i,
  input  logic          BEETLE_HREADYOUT_i,
  input  logic          FPGA_HREADYOUT_i,
  input  logic          MPS2_HREADYOUT_i,
  input  logic          BEETLE_HRESP_i,
  input  logic          FPGA_HRESP_i,
  input  logic          MPS2_HRESP_i,
  input  logic [DW-1:0] BEETLE_HRDATA_i,
  input  logic [DW-1:0] FPGA_HRDATA_i,
  input  logic [DW-1:0] MPS2_HRDATA_i,
  output logic          HREADYOUT_o,
  output logic          HRESP_o,
  output logic [DW-1:0] HRDATA_o
);

  logic [3:0] hsel_vec;
  logic [3:0] dsel;
  logic [3:0] dsel_next;
  logic       trans_active;
  logic       ds_sel;
  logic       ds_hreadyout;
  logic       ds_hresp;

  assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  always_comb begin
    hsel_vec              = '0;
    hsel_vec[DSEL_BEETLE] = BEETLE_HSEL_i;
    hsel_vec[DSEL_FPGA]   = FPGA_HSEL_i;
    hsel_vec[DSEL_MPS2]   = MPS2_HSEL_i;
    hsel_vec[DSEL_DEF]    = DEFSLAVE_HSEL_i;
  end

`ifdef MPS2_AHB_RESP_MUX_ONEHOT_CHK_EN
  logic overlap;
  assign overlap = multi_hot(hsel_vec);
  // An ambiguous decode belongs to nobody but the default slave, which errors it.
  assign ds_sel  = DEFSLAVE_HSEL_i | overlap;
  always_comb begin
    dsel_next = hsel_vec;
    if (overlap) begin
      dsel_next           = '0;
      dsel_next[DSEL_DEF] = 1'b1;
    end
  end
`else
  assign ds_sel    = DEFSLAVE_HSEL_i;
  assign dsel_next = hsel_vec;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= '0;
    end else if (HREADY) begin
      dsel <= dsel_next;
    end
  end

  mps2_ahb_default_slave u_default_slave (
    .hclk         (HCLK),
    .hresetn      (HRESETn),
    .hready       (HREADY),
    .trans_active (trans_active),
    .sel          (ds_sel),
    .hreadyout    (ds_hreadyout),
    .hresp        (ds_hresp)
  );

  // Priority order only matters if dsel ever holds several bits (no overlap check).
  always_comb begin
    HREADYOUT_o = 1'b1;
    HRESP_o     = 1'b0;
    HRDATA_o    = '0;
    if (dsel[DSEL_BEETLE]) begin
      HREADYOUT_o = BEETLE_HREADYOUT_i;
      HRESP_o     = BEETLE_HRESP_i;
      HRDATA_o    = BEETLE_HRDATA_i;
    end else if (dsel[DSEL_FPGA]) begin
      HREADYOUT_o = FPGA_HREADYOUT_i;
      HRESP_o     = FPGA_HRESP_i;
      HRDATA_o    = FPGA_HRDATA_i;
    end else if (dsel[DSEL_MPS2]) begin
      HREADYOUT_o = MPS2_HREADYOUT_i;
      HRESP_o     = MPS2_HRESP_i;
      HRDATA_o    = MPS2_HRDATA_i;
    end else if (dsel[DSEL_DEF]) begin
      HREADYOUT_o = ds_hreadyout;
      HRESP_o     = ds_hresp;
    end
  end

endmodule
